// File: rtl/iomem_timer.sv
// ---------------------------------------------------------------------------
// iomem_timer
//
// Memory-mapped 32-bit timer/compare peripheral sitting on the SoC iomem bus.
// A prescaler divides the clock into ticks; each tick advances COUNT. When
// COUNT equals COMPARE on a tick, the sticky MATCH flag sets and, if enabled,
// raises the interrupt line. Every output is zero while the block is not being
// answered, so it can be OR-combined with other iomem slaves.
//
// Register map (offset = iomem_addr[7:0]):
//   0x00 CTRL     bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN
//   0x04 PRESCALE [PRESCALE_W-1:0]
//   0x08 COUNT
//   0x0C COMPARE
//   0x10 STATUS   bit0 MATCH (sticky, write-1-to-clear)
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   iomem_valid  CPU request valid
//   iomem_ready  one-cycle completion pulse, 0 when not responding
//   iomem_wstrb  byte write strobes, 4'b0000 means read
//   iomem_addr   byte address
//   iomem_wdata  write data
//   iomem_rdata  read data while iomem_ready=1, otherwise 32'h0
//   irq          level interrupt = MATCH & IRQ_EN
// ---------------------------------------------------------------------------
module iomem_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_PRESCALE = 8'h04;
  localparam logic [7:0] OFF_COUNT    = 8'h08;
  localparam logic [7:0] OFF_COMPARE  = 8'h0C;
  localparam logic [7:0] OFF_STATUS   = 8'h10;

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [2:0]            ctrl_q, ctrl_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pscnt_q, pscnt_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           compare_q, compare_d;
  logic                  match_q, match_d;
  logic [31:0]           rdata_q, rdata_d;

  logic        inWindow;
  logic        accept;
  logic        isWrite;
  logic [7:0]  offset;
  logic        wrCtrl, wrPrescale, wrCount, wrCompare, wrStatus;
  logic [31:0] byteMask;
  logic        tick;
  logic        countHit;
  logic [31:0] countTick;
  logic [31:0] readMux;

  // Address decode and request qualification. A request is only taken in
  // IDLE, so valid held high across RESP is simply ignored for that cycle.
  assign inWindow = (iomem_addr[31:8] == BASE_ADDR[31:8]);
  assign offset   = iomem_addr[7:0];
  assign accept   = (state_q == IDLE) && iomem_valid && inWindow;
  assign isWrite  = (iomem_wstrb != 4'b0000);

  assign wrCtrl     = accept && isWrite && (offset == OFF_CTRL);
  assign wrPrescale = accept && isWrite && (offset == OFF_PRESCALE);
  assign wrCount    = accept && isWrite && (offset == OFF_COUNT);
  assign wrCompare  = accept && isWrite && (offset == OFF_COMPARE);
  assign wrStatus   = accept && isWrite && (offset == OFF_STATUS);

  // Expand byte strobes to a bit mask so every register merges lanes the
  // same way: untouched lanes keep their current value.
  assign byteMask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                     {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};

  // A tick happens on the cycle the prescale counter reaches PRESCALE, so
  // PRESCALE=N gives one tick every N+1 enabled cycles.
  assign tick     = ctrl_q[0] && (pscnt_q == prescale_q);
  assign countHit = (count_q == compare_q);

  // Bus FSM: IDLE waits for an in-window request, RESP is the single
  // response cycle and always falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (iomem_valid && inWindow) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read data is captured at accept time; write responses return zero.
  always_comb begin
    readMux = 32'h0;
    case (offset)
      OFF_CTRL:     readMux = {29'h0, ctrl_q};
      OFF_PRESCALE: readMux = 32'(prescale_q);
      OFF_COUNT:    readMux = count_q;
      OFF_COMPARE:  readMux = compare_q;
      OFF_STATUS:   readMux = {31'h0, match_q};
      default:      readMux = 32'h0;
    endcase
  end

  always_comb begin
    rdata_d = 32'h0;
    if (accept && !isWrite) begin
      rdata_d = readMux;
    end
  end

  // Control and configuration registers. CTRL only has bits in lane 0.
  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    compare_d  = compare_q;
    if (wrCtrl && iomem_wstrb[0]) begin
      ctrl_d = iomem_wdata[2:0];
    end
    if (wrPrescale) begin
      prescale_d = (prescale_q & ~byteMask[PRESCALE_W-1:0]) |
                   (iomem_wdata[PRESCALE_W-1:0] & byteMask[PRESCALE_W-1:0]);
    end
    if (wrCompare) begin
      compare_d = (compare_q & ~byteMask) | (iomem_wdata & byteMask);
    end
  end

  // Prescale counter. Any PRESCALE write restarts the division so the new
  // period takes effect cleanly; otherwise it only moves while EN is set.
  always_comb begin
    pscnt_d = pscnt_q;
    if (wrPrescale) begin
      pscnt_d = '0;
    end else if (ctrl_q[0]) begin
      if (tick) begin
        pscnt_d = '0;
      end else begin
        pscnt_d = pscnt_q + PRESCALE_W'(1);
      end
    end
  end

  // COUNT: the tick result is computed from the pre-write COUNT, then a bus
  // write overlays its enabled lanes on top so the bus value wins.
  always_comb begin
    countTick = count_q;
    if (tick) begin
      if (countHit && ctrl_q[1]) begin
        countTick = 32'h0;
      end else begin
        countTick = count_q + 32'd1;
      end
    end
    count_d = countTick;
    if (wrCount) begin
      count_d = (countTick & ~byteMask) | (iomem_wdata & byteMask);
    end
  end

  // MATCH is sticky. A new match in the same cycle as a clear keeps the flag
  // set so no event is lost.
  always_comb begin
    match_d = match_q;
    if (wrStatus && iomem_wstrb[0] && iomem_wdata[0]) begin
      match_d = 1'b0;
    end
    if (tick && countHit) begin
      match_d = 1'b1;
    end
  end

  // State register. Reset also drops an in-flight response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ctrl_q     <= 3'b000;
      prescale_q <= '0;
      pscnt_q    <= '0;
      count_q    <= 32'h0;
      compare_q  <= 32'hFFFF_FFFF;
      match_q    <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      pscnt_q    <= pscnt_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      match_q    <= match_d;
      rdata_q    <= rdata_d;
    end
  end

  // Outputs are gated to zero outside the response cycle so the bus can be
  // OR-combined with other slaves.
  assign iomem_ready = (state_q == RESP);
  assign iomem_rdata = iomem_ready ? rdata_q : 32'h0;
  assign irq         = match_q & ctrl_q[2];

endmodule

// File: tb/tb_iomem_timer.sv
// ---------------------------------------------------------------------------
// tb_iomem_timer
//
// Directed testbench for iomem_timer. Each scenario task drives the bus,
// compares what it observes with hand-computed values and counts results.
// All driving and sampling happens on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_iomem_timer;

  localparam logic [31:0] BASE = 32'h0300_0000;
  localparam logic [7:0]  OFF_CTRL     = 8'h00;
  localparam logic [7:0]  OFF_PRESCALE = 8'h04;
  localparam logic [7:0]  OFF_COUNT    = 8'h08;
  localparam logic [7:0]  OFF_COMPARE  = 8'h0C;
  localparam logic [7:0]  OFF_STATUS   = 8'h10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = 32'h0;
  logic [31:0] iomem_wdata = 32'h0;
  logic [31:0] iomem_rdata;
  logic        irq;

  int nCompared = 0;
  int nMismatched = 0;

  iomem_timer #(
    .BASE_ADDR (BASE),
    .PRESCALE_W(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr (iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Hold reset for two cycles; called and returns on a falling edge.
  task automatic applyReset();
    reset = 1'b1;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One bus transfer starting at a falling edge. Returns ready as seen in the
  // request cycle, the response cycle and the cycle after, plus response data.
  task automatic busAccess(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [31:0] rd,
                           output logic rdyEarly, output logic rdyLate,
                           output logic rdyAfter);
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wdata = data;
    iomem_wstrb = strb;
    rdyEarly    = iomem_ready;
    @(negedge clk);
    rdyLate     = iomem_ready;
    rd          = iomem_rdata;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    iomem_addr  = 32'h0;
    iomem_wdata = 32'h0;
    @(negedge clk);
    rdyAfter    = iomem_ready;
  endtask

  task automatic writeReg(input logic [7:0] off, input logic [31:0] data,
                          input logic [3:0] strb);
    logic [31:0] rd;
    logic e, l, a;
    busAccess(BASE | {24'h0, off}, data, strb, rd, e, l, a);
  endtask

  task automatic readReg(input logic [7:0] off, output logic [31:0] rd);
    logic e, l, a;
    busAccess(BASE | {24'h0, off}, 32'h0, 4'h0, rd, e, l, a);
  endtask

  task automatic test_reset();
    logic [7:0]  offs [5];
    logic [31:0] exps [5];
    logic [31:0] rd;
    logic e, l, a;
    offs = '{OFF_CTRL, OFF_PRESCALE, OFF_COUNT, OFF_COMPARE, OFF_STATUS};
    exps = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};
    applyReset();
    nCompared++;
    if (iomem_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_ready got %b expected 0", iomem_ready); end
    nCompared++;
    if (iomem_rdata !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_rdata got %h expected 0", iomem_rdata); end
    nCompared++;
    if (irq !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_irq got %b expected 0", irq); end
    for (int i = 0; i < 5; i++) begin
      busAccess(BASE | {24'h0, offs[i]}, 32'h0, 4'h0, rd, e, l, a);
      nCompared++;
      if (rd !== exps[i]) begin nMismatched++; $display("[TB] FAIL reset_read[%0d] got %h expected %h", i, rd, exps[i]); end
      nCompared++;
      if ({e, l, a} !== 3'b010) begin nMismatched++; $display("[TB] FAIL reset_ready_timing[%0d] got %b expected 010", i, {e, l, a}); end
      nCompared++;
      if (iomem_rdata !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_rdata_idle[%0d] got %h expected 0", i, iomem_rdata); end
    end
  endtask

  // Valid held high: the FSM answers every other cycle.
  task automatic test_back_to_back();
    logic [3:0]  rdySeq;
    logic [31:0] rd1, rd3;
    iomem_valid = 1'b1;
    iomem_addr  = BASE | {24'h0, OFF_COMPARE};
    iomem_wstrb = 4'h0;
    @(negedge clk); rdySeq[0] = iomem_ready; rd1 = iomem_rdata;
    @(negedge clk); rdySeq[1] = iomem_ready;
    @(negedge clk); rdySeq[2] = iomem_ready; rd3 = iomem_rdata;
    iomem_valid = 1'b0;
    @(negedge clk); rdySeq[3] = iomem_ready;
    nCompared++;
    if (rdySeq !== 4'b0101) begin nMismatched++; $display("[TB] FAIL b2b_ready_seq got %b expected 0101", rdySeq); end
    nCompared++;
    if (rd1 !== 32'hFFFF_FFFF) begin nMismatched++; $display("[TB] FAIL b2b_rdata1 got %h expected ffffffff", rd1); end
    nCompared++;
    if (rd3 !== 32'hFFFF_FFFF) begin nMismatched++; $display("[TB] FAIL b2b_rdata2 got %h expected ffffffff", rd3); end
  endtask

  task automatic test_compare_irq();
    logic [31:0] rd;
    int cycles;
    applyReset();
    writeReg(OFF_COMPARE, 32'd5, 4'hF);
    writeReg(OFF_CTRL, 32'h7, 4'hF);
    cycles = 0;
    while (irq !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    nCompared++;
    if (irq !== 1'b1) begin nMismatched++; $display("[TB] FAIL match_irq_timeout got irq=%b expected 1", irq); end
    nCompared++;
    if (cycles != 5) begin nMismatched++; $display("[TB] FAIL match_latency got %0d expected 5", cycles); end
    readReg(OFF_COUNT, rd);
    nCompared++;
    if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL match_reload got %h expected 0", rd); end
    readReg(OFF_STATUS, rd);
    nCompared++;
    if (rd !== 32'h1) begin nMismatched++; $display("[TB] FAIL match_status got %h expected 1", rd); end
    writeReg(OFF_CTRL, 32'h4, 4'hF);
    nCompared++;
    if (irq !== 1'b1) begin nMismatched++; $display("[TB] FAIL irq_held got %b expected 1", irq); end
    writeReg(OFF_STATUS, 32'h1, 4'hF);
    nCompared++;
    if (irq !== 1'b0) begin nMismatched++; $display("[TB] FAIL w1c_irq got %b expected 0", irq); end
    readReg(OFF_STATUS, rd);
    nCompared++;
    if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL w1c_status got %h expected 0", rd); end
    readReg(OFF_COUNT, rd);
    nCompared++;
    if (rd !== 32'd5) begin nMismatched++; $display("[TB] FAIL en_off_tick got %h expected 5", rd); end
  endtask

  task automatic test_prescale();
    logic [31:0] rd;
    applyReset();
    writeReg(OFF_PRESCALE, 32'd3, 4'hF);
    writeReg(OFF_CTRL, 32'h1, 4'hF);
    repeat (40) @(negedge clk);
    readReg(OFF_COUNT, rd);
    nCompared++;
    if (rd !== 32'd10) begin nMismatched++; $display("[TB] FAIL prescale_count got %0d expected 10", rd); end
    readReg(OFF_PRESCALE, rd);
    nCompared++;
    if (rd !== 32'd3) begin nMismatched++; $display("[TB] FAIL prescale_read got %h expected 3", rd); end
    writeReg(OFF_CTRL, 32'h0, 4'hF);
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd;
    logic e, l, a;
    int badCycles;
    applyReset();
    writeReg(OFF_COUNT, 32'hAABB_CCDD, 4'b0010);
    readReg(OFF_COUNT, rd);
    nCompared++;
    if (rd !== 32'h0000_CC00) begin nMismatched++; $display("[TB] FAIL lane_count got %h expected 0000cc00", rd); end
    writeReg(OFF_COMPARE, 32'h1234_5678, 4'b1001);
    readReg(OFF_COMPARE, rd);
    nCompared++;
    if (rd !== 32'h12FF_FF78) begin nMismatched++; $display("[TB] FAIL lane_compare got %h expected 12ffff78", rd); end
    busAccess(BASE | 32'h20, 32'hFFFF_FFFF, 4'hF, rd, e, l, a);
    nCompared++;
    if (l !== 1'b1) begin nMismatched++; $display("[TB] FAIL unmapped_ack got %b expected 1", l); end
    readReg(8'h20, rd);
    nCompared++;
    if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL unmapped_read got %h expected 0", rd); end
    readReg(OFF_CTRL, rd);
    nCompared++;
    if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL unmapped_ctrl got %h expected 0", rd); end
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0400_0008;
    iomem_wdata = 32'h0;
    iomem_wstrb = 4'hF;
    badCycles = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (iomem_ready !== 1'b0 || iomem_rdata !== 32'h0) badCycles++;
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    nCompared++;
    if (badCycles != 0) begin nMismatched++; $display("[TB] FAIL out_of_window got %0d responding cycles expected 0", badCycles); end
    readReg(OFF_COUNT, rd);
    nCompared++;
    if (rd !== 32'h0000_CC00) begin nMismatched++; $display("[TB] FAIL out_of_window_count got %h expected 0000cc00", rd); end
  endtask

  task automatic test_wrap_w1c();
    logic [31:0] rd;
    applyReset();
    writeReg(OFF_COUNT, 32'hFFFF_FFFE, 4'hF);
    writeReg(OFF_COMPARE, 32'd3, 4'hF);
    writeReg(OFF_CTRL, 32'h5, 4'hF);
    @(negedge clk);
    readReg(OFF_STATUS, rd);
    nCompared++;
    if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL wrap_no_match got %h expected 0", rd); end
    @(negedge clk);
    writeReg(OFF_STATUS, 32'h1, 4'hF);
    nCompared++;
    if (irq !== 1'b1) begin nMismatched++; $display("[TB] FAIL set_beats_clear_irq got %b expected 1", irq); end
    readReg(OFF_STATUS, rd);
    nCompared++;
    if (rd !== 32'h1) begin nMismatched++; $display("[TB] FAIL set_beats_clear got %h expected 1", rd); end
    writeReg(OFF_CTRL, 32'h1, 4'hF);
    nCompared++;
    if (irq !== 1'b0) begin nMismatched++; $display("[TB] FAIL irq_en_off got %b expected 0", irq); end
    readReg(OFF_STATUS, rd);
    nCompared++;
    if (rd !== 32'h1) begin nMismatched++; $display("[TB] FAIL match_retained got %h expected 1", rd); end
    writeReg(OFF_CTRL, 32'h0, 4'hF);
    readReg(OFF_COUNT, rd);
    nCompared++;
    if (rd !== 32'd12) begin nMismatched++; $display("[TB] FAIL wrap_count got %h expected 0000000c", rd); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    int lateReady;
    applyReset();
    writeReg(OFF_CTRL, 32'h6, 4'hF);
    writeReg(OFF_PRESCALE, 32'd7, 4'hF);
    writeReg(OFF_COMPARE, 32'd9, 4'hF);
    iomem_valid = 1'b1;
    iomem_addr  = BASE | {24'h0, OFF_COUNT};
    iomem_wdata = 32'h0000_1234;
    iomem_wstrb = 4'hF;
    @(negedge clk);
    reset = 1'b1;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    lateReady = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) reset = 1'b0;
      if (iomem_ready !== 1'b0) lateReady++;
    end
    nCompared++;
    if (lateReady != 0) begin nMismatched++; $display("[TB] FAIL abort_ready got %0d pulses expected 0", lateReady); end
    readReg(OFF_COUNT, rd);
    nCompared++;
    if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL abort_count got %h expected 0", rd); end
    readReg(OFF_COMPARE, rd);
    nCompared++;
    if (rd !== 32'hFFFF_FFFF) begin nMismatched++; $display("[TB] FAIL abort_compare got %h expected ffffffff", rd); end
    readReg(OFF_CTRL, rd);
    nCompared++;
    if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL abort_ctrl got %h expected 0", rd); end
    readReg(OFF_PRESCALE, rd);
    nCompared++;
    if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL abort_prescale got %h expected 0", rd); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_compare_irq();
    test_prescale();
    test_byte_lanes();
    test_wrap_w1c();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/iomem_timer.md
Name: iomem_timer

Overview:
Memory-mapped 32-bit timer/compare peripheral on the SoC's external iomem bus. It is the downstream consumer of the CPU's iomem_valid/addr/wdata/wstrb requests. It returns iomem_ready/iomem_rdata and drives one of the SoC's external interrupt inputs (irq_5) on compare match. Its outputs are zero when the block is not addressed, so they can be OR-combined with other iomem slaves.

Parameters:
BASE_ADDR, 32'h0300_0000, window base; block decodes iomem_addr[31:8] == BASE_ADDR[31:8]
PRESCALE_W, 16, width of PRESCALE register and internal prescale counter (1..32)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
iomem_valid  input  1  CPU request valid
iomem_ready  output  1  one-cycle completion pulse; 0 when not addressed
iomem_wstrb  input  4  byte write strobes; 4'b0000 = read
iomem_addr  input  32  byte address
iomem_wdata  input  32  write data
iomem_rdata  output  32  read data, valid only while iomem_ready=1, else 32'h0
irq  output  1  level interrupt = STATUS.MATCH & CTRL.IRQ_EN

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: iomem_ready=0, iomem_rdata=0, irq=0, CTRL=0, PRESCALE=0, prescale counter=0, COUNT=0, COMPARE=32'hFFFF_FFFF, MATCH=0, FSM=IDLE.
  - Reset mid-transaction aborts it: no ready pulse and no write commit.
- Register map (offset = iomem_addr[7:0]):
  - 0x00 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; other bits read 0.
  - 0x04 PRESCALE: [PRESCALE_W-1:0].
  - 0x08 COUNT.
  - 0x0C COMPARE.
  - 0x10 STATUS: bit0 MATCH, sticky, write-1-to-clear.
  - Other in-window offsets: read 0, writes ignored, still acknowledged.
- Bus FSM has two states, IDLE and RESP.
  - IDLE: if iomem_valid && in-window, go to RESP. On that same edge, commit the write (byte lanes gated by wstrb) or register the read data.
  - RESP: iomem_ready=1 and iomem_rdata=captured data for exactly one cycle, then return to IDLE unconditionally. Valid is not re-sampled in RESP, so back-to-back requests see latency 1 and throughput of one access per 2 cycles.
  - Out-of-window requests: no response, state unchanged.
  - Latency: ready asserts in the cycle after valid is first seen.
- Byte strobes apply per lane to CTRL, PRESCALE, COUNT and COMPARE. A STATUS clear needs wstrb[0] && wdata[0].
- Any write to PRESCALE (any lane) also zeroes the prescale counter.
- Tick generation when EN=1:
  - If pscnt == PRESCALE: pscnt<=0 and tick=1.
  - Otherwise pscnt<=pscnt+1.
  - PRESCALE=0 gives a tick every cycle.
- When EN=0, pscnt and COUNT hold their values and no tick occurs.
- On tick:
  - If COUNT == COMPARE: MATCH<=1, and COUNT <= AUTO_RELOAD ? 0 : COUNT+1.
  - Otherwise COUNT<=COUNT+1.
  - 32-bit wrap from FFFF_FFFF to 0 has no side effect.
- Simultaneous events:
  - Bus write to COUNT and a tick in the same cycle: the bus value wins. Match detection still uses the pre-write COUNT.
  - MATCH set and W1C in the same cycle: set wins.
  - Bus write to CTRL.EN=0 and a tick in the same cycle: the tick still applies (it was computed from the old EN).
- irq is combinational from registers and has no pulse stretching. Clearing IRQ_EN deasserts irq next cycle while MATCH is retained.

Test Plan:
- Reset, then read all five registers -> CTRL=0, PRESCALE=0, COUNT=0, COMPARE=FFFF_FFFF, STATUS=0. Each read gives ready exactly one cycle after valid; ready=0 and rdata=0 on every other cycle.
- Write COMPARE=5 and CTRL=3'b111 (PRESCALE=0) -> COUNT reaches 5, then MATCH=1 and irq=1 within 7 cycles of the EN write, and COUNT reloads to 0. Write STATUS=1 -> irq=0 on the next cycle.
- PRESCALE=3, AUTO_RELOAD=0, EN=1 -> COUNT increments once per 4 cycles. Read after 40 cycles -> COUNT=10 (±1 for the access cycles).
- Byte-lane write of wdata=32'hAABBCCDD with wstrb=4'b0010 to COUNT=0 -> COUNT=32'h0000_CC00. Write to offset 0x20 -> acked, no register changes. Access at 0x0400_0000 -> no ready ever.
- COUNT=FFFF_FFFE, COMPARE=3, EN=1 -> COUNT wraps to 0 with no MATCH, and MATCH sets at COUNT=3. Issue a W1C on STATUS in the same cycle as a match -> MATCH stays 1.
- Assert reset while the FSM is in RESP after a COUNT write -> no ready pulse is seen after reset, and all registers hold their reset values.
